// File: rtl/alu_pipe_pkg.sv
// Shared opcode encodings, flag bit positions and opcode helpers for the
// two-stage ALU pipeline.
package alu_pipe_pkg;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_NEG  = 3'b001;
   localparam logic [2:0] OP_SHL  = 3'b010;
   localparam logic [2:0] OP_SHR  = 3'b011;
   localparam logic [2:0] OP_CMP  = 3'b100;
   localparam logic [2:0] OP_SUB  = 3'b101;
   localparam logic [2:0] OP_LDI  = 3'b110;
   localparam logic [2:0] OP_PASS = 3'b111;

   localparam int FLAG_Z = 0;
   localparam int FLAG_N = 1;
   localparam int FLAG_C = 2;
   localparam int FLAG_V = 3;

   // CMP and PASS only report; every other opcode updates rd.
   function automatic logic op_writes(input logic [2:0] op);
      return (op != OP_CMP) && (op != OP_PASS);
   endfunction

endpackage

// File: rtl/alu_pipe_exec.sv
// Combinational execute unit: one result and {V,C,N,Z} flags per opcode.
module alu_exec_unit
   import alu_pipe_pkg::*;
#(
   parameter int W     = 4,
   parameter int IMM_W = 5
) (
   input  logic [2:0]       opcode,
   input  logic [W-1:0]     x,
   input  logic [W-1:0]     y,
   input  logic [IMM_W-1:0] imm,
   output logic [W-1:0]     result,
   output logic [3:0]       flags
);

   localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

   logic [W:0]   sum_add;
   logic [W:0]   sum_sub;
   logic [W:0]   shl_w;
   logic [W:0]   shr_w;
   logic [W-1:0] imm_w;
   logic [W-1:0] r;
   logic         c;
   logic         v;

   generate
      if (IMM_W >= W) begin : g_imm_trunc
         assign imm_w = imm[W-1:0];
      end else begin : g_imm_zext
         assign imm_w = {{(W-IMM_W){1'b0}}, imm};
      end
   endgenerate

   assign sum_add = {1'b0, x} + {1'b0, y};
   assign sum_sub = {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
   // One extra bit catches the last bit shifted out; amounts beyond W
   // naturally leave both result and carry at zero.
   assign shl_w   = {1'b0, x} << imm;
   assign shr_w   = {x, 1'b0} >> imm;

   always_comb begin
      r = x;
      c = 1'b0;
      v = 1'b0;
      unique case (opcode)
         OP_ADD: begin
            r = sum_add[W-1:0];
            c = sum_add[W];
            v = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
         end
         OP_NEG: begin
            r = {W{1'b0}} - x;
            c = (x == {W{1'b0}});
            v = (x == MIN_NEG);
         end
         OP_SHL: {c, r} = shl_w;
         OP_SHR: {r, c} = shr_w;
         OP_CMP, OP_SUB: begin
            r = sum_sub[W-1:0];
            c = sum_sub[W];
            v = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
         end
         OP_LDI:  r = imm_w;
         OP_PASS: r = x;
         default: r = x;
      endcase
   end

   always_comb begin
      flags         = 4'b0000;
      flags[FLAG_Z] = (r == {W{1'b0}});
      flags[FLAG_N] = r[W-1];
      flags[FLAG_C] = c;
      flags[FLAG_V] = v;
   end

   assign result = r;

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU: stage A reads operands from the register bank,
// stage B holds the executed result while the bank is written back.
module alu_pipe
   import alu_pipe_pkg::*;
#(
   parameter int  W     = 4,
   parameter int  NREG  = 16,
   parameter int  IMM_W = 5,
   localparam int AW    = $clog2(NREG)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       opcode,
   input  logic [AW-1:0]    rd_addr,
   input  logic [AW-1:0]    rs1_addr,
   input  logic [AW-1:0]    rs2_addr,
   input  logic [IMM_W-1:0] imm,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     result,
   output logic [3:0]       flags
);

   logic             a_valid_q, a_valid_d;
   logic [2:0]       a_op_q;
   logic [AW-1:0]    a_rd_q;
   logic [IMM_W-1:0] a_imm_q;
   logic [W-1:0]     a_x_q;
   logic [W-1:0]     a_y_q;

   logic             out_valid_q, out_valid_d;
   logic [W-1:0]     result_q;
   logic [3:0]       flags_q;
   logic [W-1:0]     bank_q [NREG];

   logic [W-1:0]     ex_result;
   logic [3:0]       ex_flags;
   logic             b_free;
   logic             a_adv;
   logic             a_wr;
   logic             accept;
   logic [W-1:0]     op_x;
   logic [W-1:0]     op_y;

   alu_exec_unit #(
      .W     (W),
      .IMM_W (IMM_W)
   ) u_exec (
      .opcode (a_op_q),
      .x      (a_x_q),
      .y      (a_y_q),
      .imm    (a_imm_q),
      .result (ex_result),
      .flags  (ex_flags)
   );

   assign b_free   = !out_valid_q || out_ready;
   assign a_adv    = a_valid_q && b_free;
   assign a_wr     = a_adv && op_writes(a_op_q);
   assign in_ready = !rst && (!a_valid_q || a_adv);
   assign accept   = in_valid && in_ready;

   // The bank is written on the same edge that captures the next operands,
   // so a matching writeback must be forwarded around the bank.
   always_comb begin
      op_x = bank_q[rs1_addr];
      op_y = bank_q[rs2_addr];
      if (a_wr && (a_rd_q == rs1_addr)) op_x = ex_result;
      if (a_wr && (a_rd_q == rs2_addr)) op_y = ex_result;
   end

   always_comb begin
      a_valid_d   = a_valid_q;
      out_valid_d = out_valid_q;
      if (accept)      a_valid_d = 1'b1;
      else if (a_adv)  a_valid_d = 1'b0;
      if (a_adv)          out_valid_d = 1'b1;
      else if (out_ready) out_valid_d = 1'b0;
   end

   // Stage A: operand capture
   always_ff @(posedge clk) begin
      if (accept) begin
         a_op_q  <= opcode;
         a_rd_q  <= rd_addr;
         a_imm_q <= imm;
         a_x_q   <= op_x;
         a_y_q   <= op_y;
      end
   end

   // Stage B: result register and bank writeback
   always_ff @(posedge clk) begin
      if (rst) begin
         a_valid_q   <= 1'b0;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         flags_q     <= '0;
         for (int i = 0; i < NREG; i++) bank_q[i] <= '0;
      end else begin
         a_valid_q   <= a_valid_d;
         out_valid_q <= out_valid_d;
         if (a_adv) begin
            result_q <= ex_result;
            flags_q  <= ex_flags;
         end
         if (a_wr) bank_q[a_rd_q] <= ex_result;
      end
   end

   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign flags     = flags_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Randomized and directed bench for alu_pipe against a sequential
// instruction-level reference model.
module tb_alu_pipe;

   localparam int W     = 4;
   localparam int NREG  = 16;
   localparam int IMM_W = 5;
   localparam int AW    = 4;

   localparam int ADD = 0, NEG = 1, SHL = 2, SHR = 3;
   localparam int CMP = 4, SUB = 5, LDI = 6, PASS = 7;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       opcode;
   logic [AW-1:0]    rd_addr;
   logic [AW-1:0]    rs1_addr;
   logic [AW-1:0]    rs2_addr;
   logic [IMM_W-1:0] imm;
   logic             out_valid;
   logic             out_ready;
   logic [W-1:0]     result;
   logic [3:0]       flags;

   always #5 clk = ~clk;

   alu_pipe #(.W(W), .NREG(NREG), .IMM_W(IMM_W)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .opcode    (opcode),
      .rd_addr   (rd_addr),
      .rs1_addr  (rs1_addr),
      .rs2_addr  (rs2_addr),
      .imm       (imm),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .flags     (flags)
   );

   typedef struct {
      int res;
      int flg;
      int acc;
   } item_t;

   int    checks = 0;
   int    errors = 0;
   int    bank [NREG];
   item_t q [$];
   int    dres [$];
   int    dflg [$];
   int    cyc = 0;

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   function automatic int sgn(input int v);
      return (v >= (1 << (W-1))) ? v - (1 << W) : v;
   endfunction

   function automatic item_t ref_exec(input int op, input int x, input int y, input int im);
      item_t it;
      int lim = 1 << W;
      int r = 0, c = 0, v = 0, s;
      case (op)
         ADD: begin
            s = x + y; r = s % lim; c = (s >= lim) ? 1 : 0;
            s = sgn(x) + sgn(y); v = (s >= lim/2 || s < -lim/2) ? 1 : 0;
         end
         NEG: begin
            r = (lim - x) % lim; c = (x == 0) ? 1 : 0; v = (x == lim/2) ? 1 : 0;
         end
         SHL: begin
            r = (im >= W) ? 0 : (x << im) % lim;
            c = (im >= 1 && im <= W) ? (x >> (W - im)) & 1 : 0;
         end
         SHR: begin
            r = (im >= W) ? 0 : x >> im;
            c = (im >= 1 && im <= W) ? (x >> (im - 1)) & 1 : 0;
         end
         CMP, SUB: begin
            r = (x - y + lim) % lim; c = (x >= y) ? 1 : 0;
            s = sgn(x) - sgn(y); v = (s >= lim/2 || s < -lim/2) ? 1 : 0;
         end
         LDI: r = im % lim;
         default: r = x;
      endcase
      it.res = r;
      it.flg = v*8 + c*4 + ((r >= lim/2) ? 2 : 0) + ((r == 0) ? 1 : 0);
      it.acc = 0;
      return it;
   endfunction

   // One clock: check the state left by the previous edge, drive new inputs,
   // then advance the model across the coming edge.
   task automatic step(input bit r, input bit iv, input int op, input int rd,
                       input int rs1, input int rs2, input int im, input bit ordy,
                       output bit acc);
      bit    exp_ov;
      bit    dlv;
      item_t it;
      @(negedge clk);
      check("in_ready", in_ready, (!rst && (q.size() < 2 || out_ready)) ? 1 : 0);
      exp_ov = (q.size() > 0) && (cyc >= q[0].acc + 2);
      check("out_valid", out_valid, exp_ov ? 1 : 0);
      if (exp_ov && out_valid) begin
         check("result", result, q[0].res);
         check("flags", flags, q[0].flg);
      end
      rst = r; in_valid = iv; opcode = 3'(op); rd_addr = AW'(rd);
      rs1_addr = AW'(rs1); rs2_addr = AW'(rs2); imm = IMM_W'(im); out_ready = ordy;
      acc = iv && !r && (q.size() < 2 || ordy);
      dlv = !r && exp_ov && ordy;
      if (dlv) begin
         dres.push_back(int'(result));
         dflg.push_back(int'(flags));
      end
      @(posedge clk);
      if (r) begin
         q.delete();
         foreach (bank[i]) bank[i] = 0;
      end else begin
         if (dlv) void'(q.pop_front());
         if (acc) begin
            it = ref_exec(op, bank[rs1], bank[rs2], im);
            it.acc = cyc;
            q.push_back(it);
            if (op != CMP && op != PASS) bank[rd] = it.res;
         end
      end
      cyc++;
   endtask

   task automatic issue(input int op, input int rd, input int rs1, input int rs2, input int im);
      bit acc;
      step(0, 1, op, rd, rs1, rs2, im, 1, acc);
      check("issue_acc", acc ? 1 : 0, 1);
   endtask

   task automatic drain();
      bit acc;
      for (int i = 0; i < 8 && q.size() > 0; i++) step(0, 0, 0, 0, 0, 0, 0, 1, acc);
      step(0, 0, 0, 0, 0, 0, 0, 1, acc);
      check("drain", q.size(), 0);
   endtask

   function automatic int got_res(input int i);
      return (i < dres.size()) ? dres[i] : -1;
   endfunction

   function automatic int got_flg(input int i);
      return (i < dflg.size()) ? dflg[i] : -1;
   endfunction

   initial begin
      bit acc;
      int k;
      rst = 1'b1; in_valid = 1'b0; opcode = '0; rd_addr = '0; rs1_addr = '0;
      rs2_addr = '0; imm = '0; out_ready = 1'b1;
      @(posedge clk);
      foreach (bank[i]) bank[i] = 0;

      // Reset then LDI / PASS
      step(1, 0, 0, 0, 0, 0, 0, 1, acc);
      step(1, 0, 0, 0, 0, 0, 0, 1, acc);
      #2;
      check("rst_result", result, 0);
      check("rst_flags", flags, 0);
      dres.delete(); dflg.delete();
      issue(LDI, 1, 0, 0, 5);
      issue(PASS, 0, 1, 0, 0);
      drain();
      check("ldi_res", got_res(0), 5);
      check("pass_res", got_res(1), 5);
      check("pass_flg", got_flg(1), 0);

      // ADD overflow and carry
      dres.delete(); dflg.delete();
      issue(LDI, 1, 0, 0, 7);
      issue(LDI, 2, 0, 0, 1);
      issue(ADD, 3, 1, 2, 0);
      issue(LDI, 4, 0, 0, 15);
      issue(ADD, 5, 4, 2, 0);
      drain();
      check("add_ovf_res", got_res(2), 8);
      check("add_ovf_flg", got_flg(2), 4'b1010);
      check("add_wrap_res", got_res(4), 0);
      check("add_wrap_flg", got_flg(4), 4'b0101);

      // CMP leaves rd alone, NEG boundaries
      dres.delete(); dflg.delete();
      issue(LDI, 1, 0, 0, 3);
      issue(LDI, 2, 0, 0, 5);
      issue(CMP, 1, 1, 2, 0);
      issue(PASS, 0, 1, 0, 0);
      issue(LDI, 6, 0, 0, 8);
      issue(NEG, 7, 6, 0, 0);
      issue(LDI, 8, 0, 0, 0);
      issue(NEG, 9, 8, 0, 0);
      drain();
      check("cmp_res", got_res(2), 14);
      check("cmp_flg", got_flg(2), 4'b0010);
      check("cmp_nowr", got_res(3), 3);
      check("neg8_res", got_res(5), 8);
      check("neg8_flg", got_flg(5), 4'b1010);
      check("neg0_res", got_res(7), 0);
      check("neg0_flg", got_flg(7), 4'b0101);

      // Shifts
      dres.delete(); dflg.delete();
      issue(LDI, 1, 0, 0, 11);
      issue(SHL, 2, 1, 0, 1);
      issue(SHR, 3, 1, 0, 2);
      issue(SHR, 4, 1, 0, 4);
      drain();
      check("shl_res", got_res(1), 6);
      check("shl_flg", got_flg(1), 4'b0100);
      check("shr_res", got_res(2), 2);
      check("shr_flg", got_flg(2), 4'b0100);
      check("shr4_res", got_res(3), 0);
      check("shr4_flg", got_flg(3), 4'b0101);

      // Back-to-back forwarding
      dres.delete(); dflg.delete();
      issue(LDI, 1, 0, 0, 3);
      issue(ADD, 2, 1, 1, 0);
      issue(ADD, 3, 2, 1, 0);
      drain();
      check("fwd0", got_res(0), 3);
      check("fwd1", got_res(1), 6);
      check("fwd2", got_res(2), 9);

      // Backpressure: only two instructions fit while the consumer stalls
      dres.delete(); dflg.delete();
      k = 0;
      for (int i = 0; i < 4; i++) begin
         step(0, 1, LDI, 10 + k, 0, 0, k + 1, 0, acc);
         if (acc) k++;
      end
      check("stall_acc", k, 2);
      issue(LDI, 12, 0, 0, 3);
      drain();
      check("stall_d0", got_res(0), 1);
      check("stall_d1", got_res(1), 2);
      check("stall_d2", got_res(2), 3);

      // Reset in the middle of a stall discards everything
      for (int i = 0; i < 4; i++) step(0, 1, LDI, 13 + (i % 2), 0, 0, 9, 0, acc);
      step(1, 0, 0, 0, 0, 0, 0, 0, acc);
      step(0, 0, 0, 0, 0, 0, 0, 1, acc);
      dres.delete(); dflg.delete();
      issue(PASS, 0, 10, 0, 0);
      issue(PASS, 0, 12, 0, 0);
      issue(PASS, 0, 13, 0, 0);
      drain();
      check("rst_r10", got_res(0), 0);
      check("rst_r12", got_res(1), 0);
      check("rst_r13", got_res(2), 0);

      // Random traffic with random backpressure and occasional reset
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
              int'($urandom_range(0, 7)), int'($urandom_range(0, NREG-1)),
              int'($urandom_range(0, NREG-1)), int'($urandom_range(0, NREG-1)),
              int'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0), acc);
      end
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
